dekatron: RTL and testbench



---
 rtl/dekatron.sv | 41 ++++
 tb/tb_dekatron.sv | 128 ++++++++++++
 2 files changed

// File: rtl/dekatron.sv
// dekatron: 30-position glow-transfer counting tube with one-hot cathode output
//   clk      : system clock, all state changes on its rising edge
//   reset    : asynchronous active-high reset, glow returns to position 0 at once
//   P1       : forward guide level, each rising edge steps the glow up by one
//   P2       : backward guide level, each rising edge steps the glow down by one
//   cathodes : one-hot glow position, bit k lit means position k
module dekatron #(
    parameter int N_CATHODES = 30
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  P1,
    input  logic                  P2,
    output logic [N_CATHODES-1:0] cathodes
);
    localparam int PW = $clog2(N_CATHODES);
    localparam logic [PW-1:0] LAST = PW'(N_CATHODES - 1);
    localparam logic [N_CATHODES-1:0] ONE = N_CATHODES'(1);
    logic [PW-1:0] pos, pos_next;
    logic          p1_q, p2_q, inc, dec;
    always_comb begin
        inc      = P1 & ~p1_q;
        dec      = P2 & ~p2_q;
        pos_next = (inc & ~dec) ? ((pos == LAST) ? '0 : pos + PW'(1)) :
                   (dec & ~inc) ? ((pos == '0) ? LAST : pos - PW'(1)) : pos;
    end
    // History flops reset high so a guide held through reset release is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos      <= '0;
            cathodes <= ONE;
            p1_q     <= 1'b1;
            p2_q     <= 1'b1;
        end else begin
            pos      <= pos_next;
            cathodes <= ONE << pos_next;
            p1_q     <= P1;
            p2_q     <= P2;
        end
    end
endmodule

// File: tb/tb_dekatron.sv
// tb_dekatron: scoreboard bench for the dekatron counting tube
module tb_dekatron;
    localparam int N = 30;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         P1 = 1'b0;
    logic         P2 = 1'b0;
    logic [N-1:0] cathodes;
    int           exp_q[$];
    int           errors = 0;
    int           checks = 0;
    int           ref_pos;
    bit           rp1, rp2, a, b;

    dekatron #(.N_CATHODES(N)) dut (
        .clk(clk), .reset(reset), .P1(P1), .P2(P2), .cathodes(cathodes)
    );

    always #5 clk = ~clk;

    // Drive one cycle's inputs and queue the position expected after the next edge.
    task automatic cyc(input bit r, input bit p1, input bit p2, input int e);
        @(negedge clk);
        reset = r;
        P1 = p1;
        P2 = p2;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        int           e;
        logic [N-1:0] ev;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                ev = N'(1) << e;
                checks++;
                if (cathodes !== ev) begin
                    errors++;
                    $display("FAIL cathodes t=%0t got=%h exp=%h (pos %0d)", $time, cathodes, ev, e);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        for (int k = 1; k <= N; k++) begin
            cyc(0, 1, 0, k % N);
            cyc(0, 0, 0, k % N);
        end
        for (int k = 1; k <= N; k++) begin
            cyc(0, 0, 1, (N - k) % N);
            cyc(0, 0, 0, (N - k) % N);
        end
        for (int k = 1; k <= 3; k++) begin
            cyc(0, 1, 0, k);
            cyc(0, 0, 0, k);
        end
        repeat (10) cyc(0, 1, 0, 4);
        cyc(0, 0, 0, 4);
        cyc(0, 0, 1, 3);
        cyc(0, 0, 0, 3);
        repeat (10) cyc(0, 0, 1, 2);
        cyc(0, 0, 0, 2);
        for (int k = 3; k <= 5; k++) begin
            cyc(0, 1, 0, k);
            cyc(0, 0, 0, k);
        end
        cyc(0, 1, 1, 5);
        cyc(0, 0, 0, 5);
        cyc(0, 1, 0, 6);
        cyc(0, 0, 0, 6);
        cyc(0, 1, 0, 7);
        cyc(0, 0, 0, 7);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (cathodes !== N'(1)) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", cathodes, N'(1));
        end
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        repeat (3) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 1);
        cyc(0, 0, 0, 1);
        @(negedge clk);
        #1 P1 = 1'b1;
        #2 P1 = 1'b0;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        ref_pos = 1;
        rp1 = 1'b0;
        rp2 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            a = 1'($urandom);
            b = 1'($urandom);
            if ((a && !rp1) && !(b && !rp2)) ref_pos = (ref_pos + 1) % N;
            else if ((b && !rp2) && !(a && !rp1)) ref_pos = (ref_pos + N - 1) % N;
            rp1 = a;
            rp2 = b;
            cyc(0, a, b, ref_pos);
        end
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
